seq_multiplier: RTL and testbench

//   Sequential shift-and-add multiplier, N x N -> 2N bits, one partial product per clock.

---
 rtl/seq_multiplier.sv | 98 +++++++++
 tb/tb_seq_multiplier.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: N x N -> 2N bits, one partial product per clock.
// A single N-bit adder is reused every iteration. Signed mode multiplies magnitudes and
// negates the final product when the operand signs differ.
module seq_multiplier #(
  parameter int unsigned N      = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(N);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q;
  logic [N-1:0]   mcand_q;
  logic [N-1:0]   mplier_q;
  // {hi, lo}: hi[N] of the full accumulator is always zero after the shift, so only the
  // low 2N bits are stored.
  logic [2*N-1:0] acc_q;
  logic [CntW-1:0] cnt_q;
  logic           neg_q;

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [N-1:0]   addend;
  logic [N:0]     sum;
  logic [2*N-1:0] acc_d;
  logic [2*N-1:0] prod;
  // The bit shifted out of lo each iteration is discarded.
  logic           unused_lsb;

  assign unused_lsb = acc_q[0];

  // Operand magnitudes, one add-and-shift step, and the sign-corrected final product.
  always_comb begin
    mag_a  = (SIGNED && a[N-1]) ? -a : a;
    mag_b  = (SIGNED && b[N-1]) ? -b : b;
    addend = mplier_q[0] ? mcand_q : '0;
    sum    = {1'b0, acc_q[2*N-1:N]} + {1'b0, addend};
    acc_d  = {sum, acc_q[N-1:1]};
    prod   = neg_q ? -acc_d : acc_d;
  end

  // Control FSM and datapath registers; busy/done/p are registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      p        <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            acc_q    <= '0;
            cnt_q    <= CntInit;
            neg_q    <= SIGNED & (a[N-1] ^ b[N-1]);
            busy     <= 1'b1;
            state_q  <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            p       <= prod;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: four instances (N=4/8, unsigned/signed) checked
// against an integer-arithmetic reference product.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  st;
  logic [7:0]  av [4];
  logic [7:0]  bv [4];
  wire  [3:0]  busy_w;
  wire  [3:0]  done_w;
  logic [7:0]  p0, p1;
  logic [15:0] p2, p3;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_multiplier #(.N(4), .SIGNED(1'b0)) u_m4u (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0][3:0]), .b(bv[0][3:0]),
    .busy(busy_w[0]), .done(done_w[0]), .p(p0)
  );
  seq_multiplier #(.N(4), .SIGNED(1'b1)) u_m4s (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][3:0]), .b(bv[1][3:0]),
    .busy(busy_w[1]), .done(done_w[1]), .p(p1)
  );
  seq_multiplier #(.N(8), .SIGNED(1'b0)) u_m8u (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]),
    .busy(busy_w[2]), .done(done_w[2]), .p(p2)
  );
  seq_multiplier #(.N(8), .SIGNED(1'b1)) u_m8s (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .a(av[3]), .b(bv[3]),
    .busy(busy_w[3]), .done(done_w[3]), .p(p3)
  );

  function automatic int dn(input int d);
    return (d < 2) ? 4 : 8;
  endfunction

  function automatic bit ds(input int d);
    return (d == 1) || (d == 3);
  endfunction

  function automatic logic [15:0] get_p(input int d);
    case (d)
      0:       return {8'h00, p0};
      1:       return {8'h00, p1};
      2:       return p2;
      default: return p3;
    endcase
  endfunction

  // Reference: interpret operands as n-bit integers, multiply, keep the low 2n bits.
  function automatic logic [15:0] ref_mul(input int d, input logic [7:0] x, input logic [7:0] y);
    int     n   = dn(d);
    longint one = 1;
    longint xi  = longint'(x) & ((one << n) - 1);
    longint yi  = longint'(y) & ((one << n) - 1);
    longint pr;
    if (ds(d)) begin
      if (xi >= (one << (n - 1))) xi = xi - (one << n);
      if (yi >= (one << (n - 1))) yi = yi - (one << n);
    end
    pr = (xi * yi) & ((one << (2 * n)) - 1);
    return 16'(pr);
  endfunction

  // One isolated operation with latency, busy, pulse-width and result checks.
  task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp, input string name);
    int n       = dn(d);
    int lat     = 0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    av[d] = x;
    bv[d] = y;
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    lat   = 1;
    while (done_w[d] !== 1'b1 && lat < n + 4) begin
      if (busy_w[d] !== 1'b1) busy_ok = 1'b0;
      if (lat == 2) begin
        av[d] = 8'($urandom);
        bv[d] = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat != n + 1) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, n + 1);
    end
    tests_run++;
    if (!busy_ok || busy_w[d] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy: run-phase ok=%0d at-done=%b want ok=1 at-done=0",
               name, busy_ok, busy_w[d]);
    end
    tests_run++;
    if (get_p(d) !== exp) begin
      tests_failed++;
      $display("FAIL %s product a=%h b=%h: got %h want %h", name, x, y, get_p(d), exp);
    end
    @(negedge clk);
    tests_run++;
    if (done_w[d] !== 1'b0 || get_p(d) !== exp) begin
      tests_failed++;
      $display("FAIL %s pulse/hold: done=%b p=%h want done=0 p=%h", name, done_w[d],
               get_p(d), exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    st    = '0;
    for (int i = 0; i < 4; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy_w !== 4'b0 || done_w !== 4'b0 || p0 !== 8'h0 || p1 !== 8'h0 ||
        p2 !== 16'h0 || p3 !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b p=%h/%h/%h/%h want all 0", busy_w, done_w,
               p0, p1, p2, p3);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      tests_run++;
      if (done_w !== 4'b0 || busy_w !== 4'b0) begin
        tests_failed++;
        $display("FAIL idle_no_done: busy=%b done=%b want 0", busy_w, done_w);
      end
    end
  endtask

  task automatic test_unsigned();
    run_op(0, 8'd13, 8'd11, 16'h008F, "u4_13x11");
    run_op(0, 8'd15, 8'd15, 16'h00E1, "u4_15x15");
    run_op(0, 8'd0,  8'd9,  16'h0000, "u4_0x9");
  endtask

  task automatic test_signed();
    run_op(1, 8'h08, 8'h08, 16'h0040, "s4_m8xm8");
    run_op(1, 8'h08, 8'h07, 16'h00C8, "s4_m8x7");
    run_op(1, 8'h03, 8'h0F, 16'h00FD, "s4_3xm1");
  endtask

  // start held high: each done is followed by an immediate re-accept; operands are
  // scrambled mid-run and only the values present at each accept edge matter.
  task automatic test_back_to_back();
    logic [7:0] xs [5];
    logic [7:0] ys [5];
    int lat;
    for (int i = 0; i < 5; i++) begin
      xs[i] = 8'($urandom_range(1, 15));
      ys[i] = 8'($urandom_range(1, 15));
    end
    @(negedge clk);
    av[0] = xs[0];
    bv[0] = ys[0];
    st[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (lat == 2) begin
          av[0] = 8'($urandom);
          bv[0] = 8'($urandom);
        end
      end while (done_w[0] !== 1'b1 && lat < 10);
      tests_run++;
      if (lat != 5) begin
        tests_failed++;
        $display("FAIL b2b[%0d] period: got %0d want 5", i, lat);
      end
      tests_run++;
      if (get_p(0) !== ref_mul(0, xs[i], ys[i])) begin
        tests_failed++;
        $display("FAIL b2b[%0d] product: got %h want %h", i, get_p(0), ref_mul(0, xs[i], ys[i]));
      end
      if (i < 4) begin
        av[0] = xs[i+1];
        bv[0] = ys[i+1];
      end else begin
        st[0] = 1'b0;
      end
    end
    @(negedge clk);
    tests_run++;
    if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: done=%b busy=%b want 0 0", done_w[0], busy_w[0]);
    end
  endtask

  task automatic test_abort();
    run_op(0, 8'd13, 8'd11, 16'h008F, "abort_pre");
    @(negedge clk);
    av[0] = 8'd5;
    bv[0] = 8'd6;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || p0 !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_async: busy=%b done=%b p=%h want 0 0 00", busy_w[0], done_w[0], p0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      tests_run++;
      if (done_w[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL abort_no_done: done=%b want 0", done_w[0]);
      end
    end
    run_op(0, 8'd7, 8'd9, 16'h003F, "abort_post");
  endtask

  task automatic test_random();
    logic [7:0] x, y;
    for (int d = 2; d < 4; d++) begin
      for (int i = 0; i < 1000; i++) begin
        x = 8'($urandom);
        y = 8'($urandom);
        if (i == 0) begin
          x = 8'h80;
          y = 8'h80;
        end else if (i == 1) begin
          x = 8'hFF;
          y = 8'hFF;
        end
        run_op(d, x, y, ref_mul(d, x, y), ds(d) ? "rand_s8" : "rand_u8");
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
